fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the RV32I pipeline. It replaces the bare PC register and next-PC mux in the IF stage. It decouples instruction memory from decode through a DEPTH-entry prefetch queue with a valid/ready handshake toward decode, and handles branch redirects by flushing both queued and in-flight fetches. It sits between the synchronous instruction memory (1-cycle registered read) and the IF→ID pipeline register.

## Interface
- PC_WIDTH, 9: byte-address width of the PC; the instruction memory word address is PC_WIDTH-2 bits.
- DEPTH, 2: prefetch queue entries; legal range 1..8.
- RESET_PC, 0: byte address fetched first after reset; must be word aligned.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- imem_addr  out  PC_WIDTH-2  word address to instruction memory, sampled at the clock edge.
- imem_en  out  1  read request this cycle.
- imem_rdata  in  32  read data, valid the cycle after the request.
- redirect_valid  in  1  taken branch or jump from decode.
- redirect_pc  in  PC_WIDTH  byte target address.
- out_valid  out  1  queue head holds an instruction.
- out_ready  in  1  decode accepts the head (low means stall).
- out_instr  out  32  head instruction; 0x00000013 (NOP) when empty.
- out_pc  out  PC_WIDTH  head byte address; 0 when empty.
- out_fault  out  1  head is a misaligned-target fault; only meaningful with FETCH_MISALIGN_CHECK_EN.

## Operation
- **State.** The block holds:
  - fetch_pc: next address to request.
  - rsp_pending plus rsp_pc: a request was issued last cycle.
  - A circular queue of {instr, pc, fault} with head and tail pointers and a count of 0..DEPTH.
- **Handshakes.**
  - pop = out_valid & out_ready.
  - push = rsp_pending & !redirect_valid; it stores imem_rdata with rsp_pc.
- **Issue.**
  - Issue condition: imem_en = 1 when (count - pop + rsp_pending) < DEPTH, or when redirect_valid.
  - Normal address: imem_addr = fetch_pc[PC_WIDTH-1:2].
  - Redirect address: during redirect, imem_addr = redirect_pc[PC_WIDTH-1:2] (combinational bypass).
  - On every issue, fetch_pc advances to issued address + 4, modulo 2^PC_WIDTH, so the PC wraps to 0.
- **Redirect.**
  - In the redirect cycle the queue is cleared (count, head and tail reset to 0).
  - The response arriving in that cycle is discarded, because it belongs to the old path.
  - The request issued in the redirect cycle is kept.
  - Redirect has priority over pop: the popped head is also discarded, and decode must not act on it.
- **Simultaneous events.**
  - Push and pop in the same cycle leave count unchanged.
  - Push is never attempted into a full queue; the issue rule guarantees this, and the bench asserts it.
- **Reset.**
  - Reset mid-operation clears fetch_pc to RESET_PC and clears the queue and rsp_pending.
  - Outputs during and after reset: imem_en = 0 while reset is high, out_valid = 0, out_instr = NOP, out_pc = 0, out_fault = 0.
- **Arithmetic.** PC arithmetic is unsigned PC_WIDTH bits and carries are dropped. Without the macro, redirect_pc[1:0] are ignored (treated as 00).

## Timing
- **First request.** The first request is issued the cycle after reset deasserts. Its instruction becomes out_valid two cycles after that request.
- **Redirect latency.** A redirect in cycle N issues the target in cycle N and pushes it at the end of N+1. The target appears on out_valid in N+2, giving a redirect-to-valid latency of 2.
- **Throughput.** Steady state with out_ready held high is one instruction per cycle for DEPTH ≥ 2. DEPTH = 1 gives one instruction every 2 cycles.
- **Stall.** With out_ready low, the queue fills to DEPTH and then imem_en drops. Issue resumes in the same cycle out_ready rises.
- **Output stability.** Outputs come straight from queue registers with no combinational path from imem_rdata. They are stable while out_valid & !out_ready.

## Configuration
- **FETCH_MISALIGN_CHECK_EN defined:**
  - A redirect with redirect_pc[1:0] != 00 issues no memory request.
  - It pushes one entry {NOP, redirect_pc, fault = 1}, which is visible on out_valid two cycles later.
  - The block then halts issue until the next redirect or reset.
- **FETCH_MISALIGN_CHECK_EN undefined:**
  - The low two bits are forced to zero.
  - out_fault is tied to 0 and no halt state exists.

## Test plan
- **Sequential fetch.** RESET_PC = 0, instruction memory word k = 0x1000_0000+k, out_ready = 1 -> out_pc 0,4,8,12… on consecutive cycles from the 3rd cycle after reset, with matching out_instr.
- **Backpressure.** out_ready = 0 for 6 cycles mid-stream -> count saturates at DEPTH and imem_en = 0 once full; after release the sequence resumes with no gap, duplicate or loss.
- **Redirect flush.** Redirect to 0x40 while the queue holds 0x08 and 0x0C -> neither is delivered; out_pc = 0x40 exactly 2 cycles later, followed by 0x44.
- **Redirect with concurrent pop and response.** Redirect, out_ready and a pending response all in the same cycle -> the queue ends empty and the next delivered pc is the target.
- **Wrap-around.** PC_WIDTH = 9, redirect to 0x1FC -> delivered pcs 0x1FC then 0x000.
- **Misaligned target (macro on).** Redirect to 0x42 -> single entry with out_fault = 1, out_pc = 0x042, out_instr = 0x00000013, then imem_en stays 0 until a redirect to 0x80 resumes fetch.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage fetch PC, synchronous imem request and DEPTH-entry prefetch queue toward decode.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect target yields one fault entry and halts issue.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH = 9,
  parameter int unsigned         DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic [PC_WIDTH-3:0] imem_addr,
  output logic                imem_en,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_fault
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic                fault;
  } entry_t;

  entry_t              q [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] rsp_pc;
  logic                rsp_pending;
  logic                rsp_fault;
  logic                halted;
  logic                misalign;
  logic                pop;
  logic                push;
  logic                room;
  logic [PC_WIDTH-1:0] issue_pc;
  entry_t              push_entry;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    ptr_next = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes, issue decision and head-of-queue output mux
  always_comb begin
    misalign   = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign   = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif
    out_valid  = !reset && (count != '0);
    out_instr  = NOP;
    out_pc     = '0;
    out_fault  = 1'b0;
    if (out_valid) begin
      out_instr = q[head].instr;
      out_pc    = q[head].pc;
      out_fault = q[head].fault;
    end
    pop        = out_valid && out_ready;
    push       = rsp_pending && !redirect_valid;
    // count - pop + rsp_pending < DEPTH, rearranged to avoid underflow
    room       = ({1'b0, count} + SUM_W'(rsp_pending)) < (SUM_W'(DEPTH) + SUM_W'(pop));
    issue_pc   = redirect_valid ? {redirect_pc[PC_WIDTH-1:2], 2'b00} : fetch_pc;
    imem_en    = !reset && !misalign && (redirect_valid || (room && !halted));
    imem_addr  = issue_pc[PC_WIDTH-1:2];
    push_entry = '{instr: (rsp_fault ? NOP : imem_rdata), pc: rsp_pc, fault: rsp_fault};
  end

  // Fetch PC, outstanding-response tracking and queue bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pending <= 1'b0;
      rsp_pc      <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      rsp_pending <= imem_en || misalign;
      if (imem_en || misalign) begin
        rsp_pc <= misalign ? redirect_pc : issue_pc;
      end
      if (imem_en) begin
        fetch_pc <= issue_pc + PC_WIDTH'(4);
      end
      if (redirect_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail <= ptr_next(tail);
        end
        if (pop) begin
          head <= ptr_next(head);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue payload storage; no reset needed since count gates visibility
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      q[tail] <= push_entry;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Fault marker for the pseudo-response and issue halt after a misaligned redirect
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_fault <= 1'b0;
      halted    <= 1'b0;
    end else begin
      rsp_fault <= misalign;
      if (redirect_valid) begin
        halted <= misalign;
      end
    end
  end
`else
  assign rsp_fault = 1'b0;
  assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus for fetch_unit, checked by a queue scoreboard
// holding the instruction stream decode should see (sequential PCs from the last redirect or reset).
module tb_fetch_unit;

  localparam int unsigned PC_WIDTH = 9;
  localparam int unsigned DEPTH    = 2;
  localparam logic [8:0]  RESET_PC = 9'h000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [8:0]  pc;
    logic        fault;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [8:0]  out_pc;
  logic        out_fault;

  always #5 clock = ~clock;

  fetch_unit #(.PC_WIDTH(PC_WIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  function automatic logic [31:0] word_of(input logic [8:0] pc);
    return 32'h1000_0000 + 32'(pc[8:2]);
  endfunction

  // Instruction memory: word k holds 0x1000_0000 + k, one-cycle registered read
  always @(posedge clock) if (imem_en) imem_rdata <= word_of({imem_addr, 2'b00});

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  logic [8:0] gen_pc = RESET_PC;
  bit   gen_halt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
  endtask

  // Drive one cycle's inputs and update the expected stream to match
  task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [8:0] tgt);
    reset          = rst;
    out_ready      = rdy;
    redirect_valid = rv & ~rst;
    redirect_pc    = tgt;
    if (rst) begin
      sb.delete();
      gen_pc   = RESET_PC;
      gen_halt = 1'b0;
    end else if (rv) begin
      sb.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      gen_halt = (tgt[1:0] != 2'b00);
      if (gen_halt) sb.push_back(exp_t'{instr: NOP, pc: tgt, fault: 1'b1});
`endif
      gen_pc = {tgt[8:2], 2'b00};
    end
    while (!gen_halt && sb.size() < 8) begin
      sb.push_back(exp_t'{instr: word_of(gen_pc), pc: gen_pc, fault: 1'b0});
      gen_pc = gen_pc + 9'd4;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops the scoreboard on every accepted head and checks empty/latency/stability rules
  int          wait_cyc  = 2;
  bit          mon_halt  = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_instr;
  logic [8:0]  prev_pc;
  exp_t        mon_e;

  always @(negedge clock) begin
    if (reset) begin
      check("reset_imem_en", 32'(imem_en), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_instr", out_instr, NOP);
      check("reset_out_pc", 32'(out_pc), 32'd0);
      check("reset_out_fault", 32'(out_fault), 32'd0);
      wait_cyc  = 2;
      mon_halt  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (wait_cyc > 0) check("valid_in_latency", 32'(out_valid), 32'd0);
      else if (!mon_halt) check("valid_steady", 32'(out_valid), 32'd1);
      if (prev_hold) begin
        check("stall_stable_instr", out_instr, prev_instr);
        check("stall_stable_pc", 32'(out_pc), 32'(prev_pc));
      end
      if (out_valid) begin
        if (out_ready && !redirect_valid) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pop: got pc %h required none at %0t", out_pc, $time);
          end else begin
            mon_e = sb.pop_front();
            check("pop_pc", 32'(out_pc), 32'(mon_e.pc));
            check("pop_instr", out_instr, mon_e.instr);
            check("pop_fault", 32'(out_fault), 32'(mon_e.fault));
          end
        end
      end else begin
        check("empty_instr", out_instr, NOP);
        check("empty_pc", 32'(out_pc), 32'd0);
        check("empty_fault", 32'(out_fault), 32'd0);
      end
      if (dut.push) begin
        n_checks++;
        if (int'(dut.count) < int'(DEPTH)) n_pass++;
        else $display("FAIL push_into_full: got count %0d required below %0d at %0t", dut.count, DEPTH, $time);
      end
      prev_hold  = out_valid && !out_ready && !redirect_valid;
      prev_instr = out_instr;
      prev_pc    = out_pc;
      if (redirect_valid) begin
        wait_cyc = 1;
`ifdef FETCH_MISALIGN_CHECK_EN
        mon_halt = (redirect_pc[1:0] != 2'b00);
`else
        mon_halt = 1'b0;
`endif
      end else if (wait_cyc > 0) begin
        wait_cyc--;
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 1'b0, 9'h0);
    repeat (3) tick();

    // First request the cycle after reset, visible two cycles later
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("first_issue_en", 32'(imem_en), 32'd1);
    check("first_issue_addr", 32'(imem_addr), 32'(RESET_PC[8:2]));
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("first_not_yet_valid", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("first_valid_pc", 32'(out_pc), 32'h000);
    tick();
    repeat (8) begin drive(1'b0, 1'b1, 1'b0, 9'h0); tick(); end

    // Backpressure: queue saturates and issue stops
    repeat (6) begin drive(1'b0, 1'b0, 1'b0, 9'h0); #1; tick(); end
    drive(1'b0, 1'b0, 1'b0, 9'h0); #1;
    check("full_imem_en", 32'(imem_en), 32'd0);
    check("full_count", 32'(dut.count), 32'(DEPTH));
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("release_issue_en", 32'(imem_en), 32'd1);
    tick();
    repeat (6) begin drive(1'b0, 1'b1, 1'b0, 9'h0); tick(); end

    // Redirect flush while stalled with a full queue
    repeat (4) begin drive(1'b0, 1'b0, 1'b0, 9'h0); tick(); end
    drive(1'b0, 1'b0, 1'b1, 9'h040); #1;
    check("redirect_bypass_en", 32'(imem_en), 32'd1);
    check("redirect_bypass_addr", 32'(imem_addr), 32'h10);
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("redirect_gap", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("redirect_target_pc", 32'(out_pc), 32'h040);
    tick();
    repeat (4) begin drive(1'b0, 1'b1, 1'b0, 9'h0); tick(); end

    // Redirect with concurrent pop and pending response, target wraps the PC
    drive(1'b0, 1'b1, 1'b1, 9'h1FC); tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("wrap_gap", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("wrap_first_pc", 32'(out_pc), 32'h1FC);
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("wrap_second_pc", 32'(out_pc), 32'h000);
    tick();
    repeat (3) begin drive(1'b0, 1'b1, 1'b0, 9'h0); tick(); end

    // Misaligned redirect target
    drive(1'b0, 1'b1, 1'b1, 9'h042); #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_no_issue", 32'(imem_en), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("misalign_fault", 32'(out_fault), 32'd1);
    check("misalign_pc", 32'(out_pc), 32'h042);
    check("misalign_instr", out_instr, NOP);
    tick();
    repeat (4) begin
      drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
      check("halted_no_issue", 32'(imem_en), 32'd0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 9'h080); #1;
    check("resume_issue_addr", 32'(imem_addr), 32'h20);
    check("resume_issue_en", 32'(imem_en), 32'd1);
    tick();
`else
    check("misalign_masked_addr", 32'(imem_addr), 32'h10);
    tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); tick();
    drive(1'b0, 1'b1, 1'b0, 9'h0); #1;
    check("misalign_masked_pc", 32'(out_pc), 32'h040);
    check("misalign_no_fault", 32'(out_fault), 32'd0);
    tick();
`endif
    repeat (4) begin drive(1'b0, 1'b1, 1'b0, 9'h0); tick(); end

    // Randomized traffic: stalls, aligned redirects, occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic rst_r;
      logic rdy_r;
      logic rv_r;
      logic [8:0] tgt_r;
      rst_r = ($urandom_range(0, 127) == 0);
      rdy_r = ($urandom_range(0, 3) != 0);
      rv_r  = ($urandom_range(0, 15) == 0);
      tgt_r = {7'($urandom), 2'b00};
      drive(rst_r, rdy_r, rv_r, tgt_r);
      tick();
    end

    drive(1'b0, 1'b0, 1'b0, 9'h0);
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
